rr_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 32 +++
 rtl/rr_arbiter.sv | 98 +++++++++
 tb/tb_rr_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters, never below one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the set bit in a one-hot vector (up to 16 wide); 0 when none.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set-bit search: scans start, start+1, ... modulo N.
// Optionally skips one index. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic          excl_vld,
  input  logic [IW-1:0] excl_idx,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the ring backwards so the candidate closest to start wins last.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (req[j] && !(excl_vld && (excl_idx == IW'(j)))) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held while the owner
// requests, handed directly to the next pending requester on release.
// Optional macro ARB_TIMEOUT_EN: revoke a grant held for MAX_HOLD cycles
// when another requester is waiting, pulsing PREEMPT.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 C,
  input  logic                 RN,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 BUSY,
  output logic                 PREEMPT
);

  localparam int IW = id_w(N);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner_inc;
  logic [IW-1:0] pick_start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          preempt_now;
  logic          hold;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(N - 1)) ? '0 : i + IW'(1);
  endfunction

  assign owner_inc  = wrap_inc(GNT_ID);
  assign pick_start = (state == GRANT) ? owner_inc : ptr;
  // Owner keeps the resource unless it dropped REQ or is being preempted.
  assign hold       = (state == GRANT) && REQ[GNT_ID] && !preempt_now;

  // Idle searches from ptr; handoff searches after the owner, skipping it.
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req      (REQ),
    .start    (pick_start),
    .excl_vld (state == GRANT),
    .excl_idx (GNT_ID),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  assign preempt_now = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD)) &&
                       REQ[GNT_ID] && |(REQ & ~GNT);

  // Count cycles the current owner keeps the grant, saturating at MAX_HOLD.
  always_ff @(posedge C) begin
    if (!RN)                  hold_cnt <= '0;
    else if (hold && hold_cnt != CW'(MAX_HOLD)) hold_cnt <= hold_cnt + CW'(1);
    else if (!hold)           hold_cnt <= '0;
  end

  // PREEMPT marks the first cycle of the grant that replaced a timed-out owner.
  always_ff @(posedge C) begin
    if (!RN) PREEMPT <= 1'b0;
    else     PREEMPT <= preempt_now;
  end
`else
  assign preempt_now = 1'b0;
  assign PREEMPT     = 1'b0;
`endif

  // Grant state: hold, hand over / grant fresh, or fall back to idle.
  always_ff @(posedge C) begin
    if (!RN) begin
      state  <= IDLE;
      GNT    <= '0;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
      ptr    <= '0;
    end else if (hold) begin
      state  <= GRANT;
    end else if (pick_found) begin
      state  <= GRANT;
      GNT    <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
      GNT_ID <= pick_idx;
      BUSY   <= 1'b1;
      ptr    <= wrap_inc(pick_idx);
    end else begin
      state  <= IDLE;
      GNT    <= '0;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (N=4, MAX_HOLD=8). The driver pushes the
// hand-computed response for each edge; the monitor pops and compares it.
module tb_rr_arbiter;

  logic       C;
  logic       RN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       PREEMPT;

  typedef struct {
    logic [3:0] gnt;
    logic       pre;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   to_en;

  rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .C       (C),
    .RN      (RN),
    .REQ     (REQ),
    .GNT     (GNT),
    .GNT_ID  (GNT_ID),
    .BUSY    (BUSY),
    .PREEMPT (PREEMPT)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the response to them appears after the next rise.
  task automatic step(input logic rn, input logic [3:0] req, input logic [3:0] eg,
                      input logic ep, input string nm);
    exp_t e;
    @(negedge C);
    RN  = rn;
    REQ = req;
    e.gnt  = eg;
    e.pre  = ep;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: every cycle with a pending expectation, compare all outputs.
  initial begin
    exp_t       e;
    logic [1:0] eid;
    forever begin
      @(posedge C);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        eid = 2'd0;
        for (int i = 0; i < 4; i++) if (e.gnt[i]) eid = 2'(i);
        chk({e.name, ".gnt"},     32'(GNT),     32'(e.gnt));
        chk({e.name, ".gnt_id"},  32'(GNT_ID),  32'(eid));
        chk({e.name, ".busy"},    32'(BUSY),    32'(|e.gnt));
        chk({e.name, ".preempt"}, 32'(PREEMPT), 32'(e.pre));
      end
    end
  end

  initial begin
    int waited;
`ifdef ARB_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    RN  = 1'b0;
    REQ = 4'b0000;

    // Reset holds everything low even with all requests up.
    step(0, 4'b1111, 4'b0000, 0, "rst0");
    step(0, 4'b1111, 4'b0000, 0, "rst1");
    step(1, 4'b1111, 4'b0001, 0, "rst_rel");

    // Rotation: each owner holds two cycles, then drops and re-raises.
    step(1, 4'b1111, 4'b0001, 0, "rot0_hold");
    step(1, 4'b1110, 4'b0010, 0, "rot1");
    step(1, 4'b1111, 4'b0010, 0, "rot1_hold");
    step(1, 4'b1101, 4'b0100, 0, "rot2");
    step(1, 4'b1111, 4'b0100, 0, "rot2_hold");
    step(1, 4'b1011, 4'b1000, 0, "rot3");
    step(1, 4'b1111, 4'b1000, 0, "rot3_hold");
    step(1, 4'b0111, 4'b0001, 0, "rot0_wrap");
    step(1, 4'b0000, 4'b0000, 0, "rot_idle");

    // Single requester 2 for three cycles.
    step(1, 4'b0100, 4'b0100, 0, "single_a");
    step(1, 4'b0100, 4'b0100, 0, "single_b");
    step(1, 4'b0100, 4'b0100, 0, "single_c");
    step(1, 4'b0000, 4'b0000, 0, "single_idle");

    // Owner 3 releases with 0 and 1 pending: wraps to 0, ptr becomes 1.
    step(1, 4'b1000, 4'b1000, 0, "wrap_own3");
    step(1, 4'b0011, 4'b0001, 0, "wrap_hand0");
    step(1, 4'b0000, 4'b0000, 0, "wrap_idle");
    step(1, 4'b0011, 4'b0010, 0, "wrap_ptr1");
    step(1, 4'b0000, 4'b0000, 0, "wrap_idle2");

    // Reset while 2 owns; ptr restarts at 0 so 1 beats 2.
    step(1, 4'b0100, 4'b0100, 0, "mrst_own2");
    step(0, 4'b0100, 4'b0000, 0, "mrst_drop");
    step(1, 4'b0110, 4'b0010, 0, "mrst_ptr0");
    step(1, 4'b0000, 4'b0000, 0, "mrst_idle");

    // Long hold by 0 with 1 waiting: preempted only with the timeout feature.
    step(1, 4'b0011, 4'b0001, 0, "hold_grant");
    for (int k = 1; k <= 11; k++) begin
      if (to_en && k >= 9) step(1, 4'b0011, 4'b0010, (k == 9), $sformatf("hold_k%0d", k));
      else                 step(1, 4'b0011, 4'b0001, 0,        $sformatf("hold_k%0d", k));
    end
    step(1, 4'b0000, 4'b0000, 0, "hold_idle");

    // Long hold with nobody else waiting: never preempted.
    step(1, 4'b0001, 4'b0001, 0, "solo_grant");
    for (int k = 1; k <= 11; k++)
      step(1, 4'b0001, 4'b0001, 0, $sformatf("solo_k%0d", k));
    step(1, 4'b0000, 4'b0000, 0, "solo_idle");

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge C);
      waited++;
    end
    #2;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
